// File: rtl/dp_seq_pkg.sv
// Shared types and Am2901 microinstruction constants for the datapath sequencer.
// Ialu words are composed as {destination, function, source}.
package dp_seq_pkg;

    typedef enum logic [1:0] {
        OP_MUL = 2'd0,
        OP_SHR = 2'd1,
        OP_SHL = 2'd2,
        OP_NOP = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_STEP,
        S_DONE
    } state_t;

    localparam logic [2:0] SRC_AQ = 3'd0;
    localparam logic [2:0] SRC_AB = 3'd1;
    localparam logic [2:0] SRC_ZQ = 3'd2;
    localparam logic [2:0] SRC_ZB = 3'd3;
    localparam logic [2:0] SRC_ZA = 3'd4;
    localparam logic [2:0] SRC_DA = 3'd5;
    localparam logic [2:0] SRC_DQ = 3'd6;
    localparam logic [2:0] SRC_DZ = 3'd7;

    localparam logic [2:0] FN_ADD   = 3'd0;
    localparam logic [2:0] FN_SUBR  = 3'd1;
    localparam logic [2:0] FN_SUBS  = 3'd2;
    localparam logic [2:0] FN_OR    = 3'd3;
    localparam logic [2:0] FN_AND   = 3'd4;
    localparam logic [2:0] FN_NOTRS = 3'd5;
    localparam logic [2:0] FN_EXOR  = 3'd6;
    localparam logic [2:0] FN_EXNOR = 3'd7;

    localparam logic [2:0] DST_QREG  = 3'd0;
    localparam logic [2:0] DST_NOP   = 3'd1;
    localparam logic [2:0] DST_RAMA  = 3'd2;
    localparam logic [2:0] DST_RAMF  = 3'd3;
    localparam logic [2:0] DST_RAMQD = 3'd4;
    localparam logic [2:0] DST_RAMD  = 3'd5;
    localparam logic [2:0] DST_RAMQU = 3'd6;
    localparam logic [2:0] DST_RAMU  = 3'd7;

    function automatic logic [8:0] ialu_word(input logic [2:0] dst,
                                             input logic [2:0] fn,
                                             input logic [2:0] src);
        return {dst, fn, src};
    endfunction

    localparam logic [8:0] IALU_IDLE    = ialu_word(DST_NOP,   FN_OR,  SRC_ZA);
    localparam logic [8:0] IALU_LOADQ   = ialu_word(DST_QREG,  FN_OR,  SRC_DZ);
    localparam logic [8:0] IALU_CLR     = ialu_word(DST_RAMF,  FN_AND, SRC_ZB);
    localparam logic [8:0] IALU_MULADD  = ialu_word(DST_RAMQD, FN_ADD, SRC_AB);
    localparam logic [8:0] IALU_MULSKIP = ialu_word(DST_RAMQD, FN_ADD, SRC_ZB);
    localparam logic [8:0] IALU_SHR     = ialu_word(DST_RAMD,  FN_ADD, SRC_ZB);
    localparam logic [8:0] IALU_SHL     = ialu_word(DST_RAMU,  FN_ADD, SRC_ZB);

endpackage

// File: rtl/dp_sequencer.sv
// Multi-cycle microsequencer driving the Am2901/2902/2904 datapath for MUL, SHR and SHL.
// Outputs are decoded from registered state; q_lsb is the only combinational input path.
module dp_sequencer
    import dp_seq_pkg::*;
#(
    parameter logic [12:0] ISS_NOP = 13'h0000,
    parameter logic [12:0] ISS_SHR = 13'h0000,
    parameter logic [12:0] ISS_SHL = 13'h0000
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        mode32_in,
    input  logic [6:0]  amount,
    input  logic [3:0]  ra_in,
    input  logic [3:0]  rb_in,
    input  logic        abort,
    input  logic        q_lsb,
    output logic        busy,
    output logic        done,
    output logic        d_sel,
    output logic [8:0]  Ialu,
    output logic [3:0]  A,
    output logic [3:0]  B,
    output logic        Cin,
    output logic [12:0] Iss,
    output logic        nCEM,
    output logic        nCEN,
    output logic        mode32
);

    state_t     state;
    op_t        op_q;
    op_t        op_in;
    logic [6:0] cnt;
    logic [3:0] ra_q;
    logic [3:0] rb_q;
    logic [6:0] lim;
    logic [6:0] n_req;

    // Step count requested by the incoming operation, saturated to the word width.
    always_comb begin
        op_in = op_t'(op);
        lim   = mode32_in ? 7'd32 : 7'd64;
        case (op_in)
            OP_MUL:         n_req = lim;
            OP_SHR, OP_SHL: n_req = (amount > lim) ? lim : amount;
            default:        n_req = 7'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state  <= S_IDLE;
            op_q   <= OP_NOP;
            cnt    <= 7'd0;
            ra_q   <= 4'd0;
            rb_q   <= 4'd0;
            mode32 <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op_in;
                        mode32 <= mode32_in;
                        ra_q   <= ra_in;
                        rb_q   <= rb_in;
                        cnt    <= n_req;
                        if (op_in == OP_MUL)
                            state <= S_LOAD;
                        else if (n_req != 7'd0)
                            state <= S_STEP;
                        else
                            state <= S_DONE;
                    end
                end
                S_LOAD:  state <= abort ? S_IDLE : S_CLEAR;
                S_CLEAR: state <= abort ? S_IDLE : S_STEP;
                S_STEP: begin
                    if (abort)
                        state <= S_IDLE;
                    else if (cnt == 7'd1)
                        state <= S_DONE;
                    else
                        cnt <= cnt - 7'd1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        d_sel = 1'b0;
        Ialu  = IALU_IDLE;
        Iss   = ISS_NOP;
        nCEM  = 1'b1;
        A     = (state == S_IDLE) ? 4'd0 : ra_q;
        B     = (state == S_IDLE) ? 4'd0 : rb_q;
        case (state)
            S_LOAD: begin
                busy  = 1'b1;
                d_sel = 1'b1;
                Ialu  = IALU_LOADQ;
            end
            S_CLEAR: begin
                busy = 1'b1;
                Ialu = IALU_CLR;
            end
            S_STEP: begin
                busy = 1'b1;
                // Status is captured only on the last step so flags describe the final result.
                nCEM = (cnt != 7'd1);
                case (op_q)
                    OP_MUL: begin
                        Ialu = q_lsb ? IALU_MULADD : IALU_MULSKIP;
                        Iss  = ISS_SHR;
                    end
                    OP_SHL: begin
                        Ialu = IALU_SHL;
                        Iss  = ISS_SHL;
                    end
                    default: begin
                        Ialu = IALU_SHR;
                        Iss  = ISS_SHR;
                    end
                endcase
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign Cin  = 1'b0;
    assign nCEN = 1'b1;

endmodule

// File: tb/tb_dp_sequencer.sv
// Self-checking bench for dp_sequencer: directed scenarios plus randomized operations
// compared cycle by cycle against a phase-list model of each operation.
module tb_dp_sequencer;

    localparam logic [12:0] T_NOP = 13'h0101;
    localparam logic [12:0] T_SHR = 13'h0A5A;
    localparam logic [12:0] T_SHL = 13'h1234;

    logic        clk = 1'b0;
    logic        nreset;
    logic        start;
    logic [1:0]  op;
    logic        mode32_in;
    logic [6:0]  amount;
    logic [3:0]  ra_in;
    logic [3:0]  rb_in;
    logic        abort;
    logic        q_lsb;
    logic        busy;
    logic        done;
    logic        d_sel;
    logic [8:0]  Ialu;
    logic [3:0]  A;
    logic [3:0]  B;
    logic        Cin;
    logic [12:0] Iss;
    logic        nCEM;
    logic        nCEN;
    logic        mode32;

    logic [36:0] obs;
    int          total = 0;
    int          bad   = 0;
    logic        cur_m32;

    dp_sequencer #(
        .ISS_NOP(T_NOP),
        .ISS_SHR(T_SHR),
        .ISS_SHL(T_SHL)
    ) dut (
        .clk(clk), .nreset(nreset), .start(start), .op(op), .mode32_in(mode32_in),
        .amount(amount), .ra_in(ra_in), .rb_in(rb_in), .abort(abort), .q_lsb(q_lsb),
        .busy(busy), .done(done), .d_sel(d_sel), .Ialu(Ialu), .A(A), .B(B), .Cin(Cin),
        .Iss(Iss), .nCEM(nCEM), .nCEN(nCEN), .mode32(mode32)
    );

    always #5 clk = ~clk;

    assign obs = {busy, done, d_sel, Ialu, A, B, Cin, Iss, nCEM, nCEN, mode32};

    function automatic logic [36:0] vec(input logic b, input logic d, input logic ds,
                                        input logic [8:0] ia, input logic [3:0] a,
                                        input logic [3:0] bb, input logic [12:0] iss,
                                        input logic nc, input logic m);
        return {b, d, ds, ia, a, bb, 1'b0, iss, nc, 1'b1, m};
    endfunction

    function automatic logic [36:0] idle_vec(input logic m);
        return vec(1'b0, 1'b0, 1'b0, 9'h05C, 4'd0, 4'd0, T_NOP, 1'b1, m);
    endfunction

    function automatic logic [36:0] step_vec(input int opc, input logic q, input logic last,
                                             input logic [3:0] a, input logic [3:0] bb,
                                             input logic m);
        logic [8:0]  ia;
        logic [12:0] iss;
        if (opc == 0) begin
            ia  = q ? 9'h101 : 9'h103;
            iss = T_SHR;
        end else if (opc == 2) begin
            ia  = 9'h1C3;
            iss = T_SHL;
        end else begin
            ia  = 9'h143;
            iss = T_SHR;
        end
        return vec(1'b1, 1'b0, 1'b0, ia, a, bb, iss, ~last, m);
    endfunction

    task automatic check(input string tag, input logic [36:0] got, input logic [36:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Entered and left just after a rising edge with the DUT in IDLE.
    task automatic run_op(input int opc, input logic m32, input int amt,
                          input logic [3:0] ra, input logic [3:0] rb,
                          input int abort_at, input bit alt_q);
        int lim, n, pre, tot, s;
        logic q;
        logic [36:0] exp;
        start     = 1'b1;
        op        = opc[1:0];
        mode32_in = m32;
        amount    = amt[6:0];
        ra_in     = ra;
        rb_in     = rb;
        abort     = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("idle_pre", obs, idle_vec(cur_m32));
        next_cycle();
        cur_m32 = m32;
        lim = m32 ? 32 : 64;
        if (opc == 0)      n = lim;
        else if (opc == 3) n = 0;
        else               n = (amt > lim) ? lim : amt;
        pre = (opc == 0) ? 2 : 0;
        tot = pre + n + 1;
        for (int k = 0; k < tot; k++) begin
            start     = 1'($urandom_range(0, 1));
            op        = 2'($urandom_range(0, 3));
            mode32_in = 1'($urandom_range(0, 1));
            amount    = 7'($urandom_range(0, 127));
            ra_in     = 4'($urandom_range(0, 15));
            rb_in     = 4'($urandom_range(0, 15));
            s         = k - pre;
            q         = (alt_q && k >= pre) ? (s % 2 == 0) : 1'($urandom_range(0, 1));
            q_lsb     = q;
            abort     = (k == abort_at);
            if (k == 0 && pre == 2)
                exp = vec(1'b1, 1'b0, 1'b1, 9'h01F, ra, rb, T_NOP, 1'b1, m32);
            else if (k == 1 && pre == 2)
                exp = vec(1'b1, 1'b0, 1'b0, 9'h0E3, ra, rb, T_NOP, 1'b1, m32);
            else if (s < n)
                exp = step_vec(opc, q, s == n - 1, ra, rb, m32);
            else begin
                exp   = vec(1'b0, 1'b1, 1'b0, 9'h05C, ra, rb, T_NOP, 1'b1, m32);
                abort = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            check($sformatf("op%0d_cyc%0d", opc, k), obs, exp);
            next_cycle();
            if (k == abort_at) begin
                abort = 1'b0;
                start = 1'b0;
                @(negedge clk);
                check("abort_idle", obs, idle_vec(m32));
                next_cycle();
                return;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("idle_post", obs, idle_vec(m32));
        next_cycle();
    endtask

    initial begin
        nreset    = 1'b0;
        start     = 1'b1;
        op        = 2'd0;
        mode32_in = 1'b1;
        amount    = 7'd0;
        ra_in     = 4'd7;
        rb_in     = 4'd9;
        abort     = 1'b0;
        q_lsb     = 1'b0;
        cur_m32   = 1'b0;

        // Reset held with start asserted.
        next_cycle();
        @(negedge clk);
        check("reset_1", obs, idle_vec(1'b0));
        next_cycle();
        @(negedge clk);
        check("reset_2", obs, idle_vec(1'b0));
        start  = 1'b0;
        nreset = 1'b1;
        next_cycle();

        run_op(0, 1'b1, 0, 4'd3, 4'd5, -1, 1'b1);    // MUL 32-bit, alternating q_lsb
        run_op(2, 1'b0, 100, 4'd7, 4'd9, -1, 1'b0);  // SHL 64-bit saturating
        run_op(1, 1'b1, 0, 4'd1, 4'd2, -1, 1'b0);    // SHR by zero
        run_op(0, 1'b0, 0, 4'd4, 4'd6, 6, 1'b0);     // MUL aborted on 5th step
        next_cycle();
        run_op(0, 1'b1, 0, 4'd8, 4'd10, -1, 1'b0);
        run_op(3, 1'b0, 20, 4'd2, 4'd3, -1, 1'b0);   // reserved op
        run_op(1, 1'b1, 40, 4'd5, 4'd11, -1, 1'b0);  // SHR 32-bit saturating

        // Reset in the middle of a multiply, with start held.
        start = 1'b1; op = 2'd0; mode32_in = 1'b0; ra_in = 4'd1; rb_in = 4'd2;
        next_cycle();
        repeat (5) next_cycle();
        nreset = 1'b0;
        next_cycle();
        nreset = 1'b1;
        start  = 1'b0;
        cur_m32 = 1'b0;
        @(negedge clk);
        check("midstep_reset", obs, idle_vec(1'b0));
        next_cycle();

        // Start held through DONE is taken only in the following IDLE cycle.
        start = 1'b1; op = 2'd1; mode32_in = 1'b1; amount = 7'd3; ra_in = 4'd2; rb_in = 4'd4;
        next_cycle();
        cur_m32 = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check($sformatf("hold_step%0d", s), obs, step_vec(1, 1'b0, s == 2, 4'd2, 4'd4, 1'b1));
            next_cycle();
        end
        @(negedge clk);
        check("hold_done", obs, vec(1'b0, 1'b1, 1'b0, 9'h05C, 4'd2, 4'd4, T_NOP, 1'b1, 1'b1));
        next_cycle();
        @(negedge clk);
        check("hold_idle", obs, idle_vec(1'b1));
        next_cycle();
        @(negedge clk);
        check("hold_restart", obs, step_vec(1, 1'b0, 1'b0, 4'd2, 4'd4, 1'b1));
        start = 1'b0;
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        @(negedge clk);
        check("hold_abort_idle", obs, idle_vec(1'b1));
        next_cycle();

        // Randomized operations.
        for (int i = 0; i < 12; i++) begin
            int opc, amt, ab;
            logic m;
            opc = $urandom_range(0, 3);
            m   = 1'($urandom_range(0, 1));
            amt = $urandom_range(0, 127);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
            if (ab >= 0 && (opc == 3 || (opc != 0 && amt == 0))) ab = -1;
            if (ab >= 0 && opc != 0 && ab >= amt) ab = -1;
            run_op(opc, m, amt, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ab, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
